// File: rtl/pattern_sequencer.sv
// Chart-driven note sequencer: fetches notes from a synchronous ROM and allocates them to sprite
// slots. Define LOOP_EN to restart playback at address 0 on the end marker instead of finishing.
module pattern_sequencer #(
  parameter int unsigned TICK_DIV  = 800000,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned SPAWN_Y   = 200,
  parameter int unsigned TOP_Y     = 8
) (
  input  logic                   CLOCK_24,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pause,
  output logic [ADDR_W-1:0]      chart_addr,
  input  logic [7:0]             chart_data,
  input  logic [8*NUM_SLOTS-1:0] slot_y_pos,
  output logic [4*NUM_SLOTS-1:0] slot_cmd,
  output logic [NUM_SLOTS-1:0]   slot_reset,
  output logic [7:0]             y_ini_pos,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             stall_cnt
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned HoldW = $clog2(TICK_DIV + 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StSpawn, StWaitGap, StDone
  } state_e;

  state_e state_q, state_d;

  logic [TickW-1:0]                tick_cnt_q;
  logic                            tick;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [3:0]                      cmd_q, cmd_d;
  logic [3:0]                      gap_q, gap_d;
  logic [7:0]                      stall_q, stall_d;
  logic [4*NUM_SLOTS-1:0]          slot_cmd_q, slot_cmd_d;
  logic [NUM_SLOTS-1:0]            slot_rst_q, slot_rst_d;
  logic [NUM_SLOTS-1:0]            active_q, active_d;
  logic [NUM_SLOTS-1:0][HoldW-1:0] hold_q, hold_d;
  logic [NUM_SLOTS-1:0]            slot_free;
  logic [NUM_SLOTS-1:0]            spawn_sel;
  logic                            spawn_go;

  assign tick = !pause && (tick_cnt_q == TickW'(TICK_DIV - 1));

  // A slot is free only when neither holding reset nor active; lowest set bit wins.
  assign slot_free = ~slot_rst_q & ~active_q;
  assign spawn_sel = slot_free & (~slot_free + NUM_SLOTS'(1));
  assign spawn_go  = (state_q == StSpawn) && (|slot_free);

  always_ff @(posedge CLOCK_24) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    gap_d   = gap_q;
    stall_d = stall_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          addr_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        cmd_d = chart_data[3:0];
        gap_d = chart_data[7:4];
        if (chart_data[3:0] == 4'd0) begin
`ifdef LOOP_EN
          addr_d  = '0;
          state_d = StFetch;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StSpawn;
        end
      end
      StSpawn: begin
        if (spawn_go) begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = (gap_q == 4'd0) ? StFetch : StWaitGap;
        end else if (stall_q != 8'hff) begin
          stall_d = stall_q + 8'd1;
        end
      end
      StWaitGap: begin
        if (tick) begin
          gap_d = gap_q - 4'd1;
          if (gap_q == 4'd1) state_d = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = 1'b1;
    done = 1'b0;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StDone: begin
        busy = 1'b0;
        done = &slot_free;
      end
      default: ;
    endcase
  end

  // Retire is evaluated on the current slot state, so a slot freed this cycle is not visible
  // to spawn selection until the next one.
  always_comb begin
    slot_cmd_d = slot_cmd_q;
    slot_rst_d = slot_rst_q;
    active_d   = active_q;
    hold_d     = hold_q;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_rst_q[i]) begin
        if (hold_q[i] == '0) begin
          slot_rst_d[i] = 1'b0;
          active_d[i]   = 1'b1;
        end else begin
          hold_d[i] = hold_q[i] - HoldW'(1);
        end
      end else if (active_q[i] && (slot_y_pos[8*i +: 8] <= 8'(TOP_Y))) begin
        active_d[i]          = 1'b0;
        slot_cmd_d[4*i +: 4] = 4'd0;
      end
      if (spawn_go && spawn_sel[i]) begin
        slot_cmd_d[4*i +: 4] = cmd_q;
        slot_rst_d[i]        = 1'b1;
        hold_d[i]            = HoldW'(TICK_DIV);
      end
    end
  end

  always_ff @(posedge CLOCK_24) begin
    if (reset) begin
      tick_cnt_q <= '0;
      addr_q     <= '0;
      cmd_q      <= '0;
      gap_q      <= '0;
      stall_q    <= '0;
      slot_cmd_q <= '0;
      slot_rst_q <= '0;
      active_q   <= '0;
      hold_q     <= '0;
    end else begin
      if (!pause) tick_cnt_q <= tick ? '0 : tick_cnt_q + TickW'(1);
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      gap_q      <= gap_d;
      stall_q    <= stall_d;
      slot_cmd_q <= slot_cmd_d;
      slot_rst_q <= slot_rst_d;
      active_q   <= active_d;
      hold_q     <= hold_d;
    end
  end

  assign chart_addr = addr_q;
  assign slot_cmd   = slot_cmd_q;
  assign slot_reset = slot_rst_q;
  assign stall_cnt  = stall_q;
  assign y_ini_pos  = 8'(SPAWN_Y);

endmodule
